// File: rtl/i2c_txn_sequencer_pkg.sv
// i2c_txn_sequencer_pkg: shared definitions for the I2C transaction sequencer.
// This package holds the master command codes, the FSM state encodings, the latched
// request header and a helper that builds the address byte.
package i2c_txn_sequencer_pkg;

  // Commands presented to the bit-level master on cmd.
  localparam logic [2:0] k_IDLE_CMD      = 3'd0;
  localparam logic [2:0] k_START_CMD     = 3'd1;
  localparam logic [2:0] k_WRITE_CMD     = 3'd2;
  localparam logic [2:0] k_READ_ACK_CMD  = 3'd3;
  localparam logic [2:0] k_READ_NACK_CMD = 3'd4;
  localparam logic [2:0] k_STOP_CMD      = 3'd5;

  // Sequencer states.
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_START  = 4'd1;
  localparam logic [3:0] S_ADDR   = 4'd2;
  localparam logic [3:0] S_WFETCH = 4'd3;
  localparam logic [3:0] S_WDATA  = 4'd4;
  localparam logic [3:0] S_RDATA  = 4'd5;
  localparam logic [3:0] S_STOP   = 4'd6;
  localparam logic [3:0] S_WAIT   = 4'd7;
  localparam logic [3:0] S_FINISH = 4'd8;

  // Address and direction captured when a request is accepted.
  typedef struct packed {
    logic [6:0] addr;
    logic       rw;
  } txn_hdr_t;

  // The address byte on the wire is the 7-bit address followed by the R/W bit.
  function automatic logic [7:0] addr_byte(input txn_hdr_t h);
    return {h.addr, h.rw};
  endfunction

endpackage

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: turns one transaction request into the START / address /
// data / STOP command sequence for a bit-level I2C master, streams write bytes
// in and read bytes out, and reports nack/abort with a done pulse.
// Optional watchdog: define I2C_SEQ_TIMEOUT_EN to abort a transaction whose
// master command does not complete within TIMEOUT_CYCLES cycles.
module i2c_txn_sequencer
  import i2c_txn_sequencer_pkg::*;
#(
  parameter int unsigned LEN_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_addr,
  input  logic             req_rw,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic             nack,
  output logic             abort,
  output logic [2:0]       cmd,
  output logic [7:0]       tx_byte,
  output logic             write,
  input  logic             m_ready,
  input  logic             m_done,
  input  logic             m_ack,
  input  logic [7:0]       m_rx_byte
);

  logic [3:0]       state;
  logic [3:0]       ret_state;
  txn_hdr_t         hdr;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] rem_dec;
  logic [7:0]       wbyte;
  logic             nack_flag;
  logic             abort_flag;
  logic             timeout;

  // The remaining-byte counter saturates at zero instead of wrapping.
  assign rem_dec = (remaining != '0) ? remaining - LEN_W'(1) : '0;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // Watchdog counts cycles spent in WAIT; any exit from WAIT (including the
  // next command strobe) restarts it from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state != S_WAIT) begin
      wd_cnt <= '0;
    end else if (!timeout) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign timeout = (state == S_WAIT) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Main sequencer: one command in flight at a time, every output registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      ret_state  <= S_IDLE;
      hdr        <= '0;
      remaining  <= '0;
      wbyte      <= '0;
      nack_flag  <= 1'b0;
      abort_flag <= 1'b0;
      req_ready  <= 1'b1;
      wr_ready   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      done       <= 1'b0;
      nack       <= 1'b0;
      abort      <= 1'b0;
      cmd        <= k_IDLE_CMD;
      tx_byte    <= '0;
      write      <= 1'b0;
    end else begin
      write    <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            hdr       <= {req_addr, req_rw};
            remaining <= req_len;
            req_ready <= 1'b0;
            state     <= S_START;
          end
        end
        S_START: begin
          if (m_ready) begin
            cmd       <= k_START_CMD;
            write     <= 1'b1;
            ret_state <= S_START;
            state     <= S_WAIT;
          end
        end
        S_ADDR: begin
          if (m_ready) begin
            cmd       <= k_WRITE_CMD;
            tx_byte   <= addr_byte(hdr);
            write     <= 1'b1;
            ret_state <= S_ADDR;
            state     <= S_WAIT;
          end
        end
        S_WFETCH: begin
          if (wr_valid && wr_ready) begin
            wbyte    <= wr_data;
            wr_ready <= 1'b0;
            state    <= S_WDATA;
          end
        end
        S_WDATA: begin
          if (m_ready) begin
            cmd       <= k_WRITE_CMD;
            tx_byte   <= wbyte;
            write     <= 1'b1;
            ret_state <= S_WDATA;
            state     <= S_WAIT;
          end
        end
        S_RDATA: begin
          if (m_ready) begin
            // The last byte of a read is NACKed so the target releases SDA.
            cmd       <= (remaining > LEN_W'(1)) ? k_READ_ACK_CMD : k_READ_NACK_CMD;
            write     <= 1'b1;
            ret_state <= S_RDATA;
            state     <= S_WAIT;
          end
        end
        S_STOP: begin
          if (m_ready) begin
            cmd       <= k_STOP_CMD;
            write     <= 1'b1;
            ret_state <= S_STOP;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (m_done) begin
            case (ret_state)
              S_START: state <= S_ADDR;
              S_ADDR: begin
                if (!m_ack) begin
                  nack_flag <= 1'b1;
                  state     <= S_STOP;
                end else if (remaining == '0) begin
                  state <= S_STOP;
                end else if (!hdr.rw) begin
                  wr_ready <= 1'b1;
                  state    <= S_WFETCH;
                end else begin
                  state <= S_RDATA;
                end
              end
              S_WDATA: begin
                if (!m_ack) begin
                  nack_flag <= 1'b1;
                  state     <= S_STOP;
                end else begin
                  remaining <= rem_dec;
                  if (rem_dec == '0) begin
                    state <= S_STOP;
                  end else begin
                    wr_ready <= 1'b1;
                    state    <= S_WFETCH;
                  end
                end
              end
              S_RDATA: begin
                rd_valid  <= 1'b1;
                rd_data   <= m_rx_byte;
                remaining <= rem_dec;
                state     <= (rem_dec == '0) ? S_STOP : S_RDATA;
              end
              S_STOP: begin
                done  <= 1'b1;
                nack  <= nack_flag;
                abort <= abort_flag;
                state <= S_FINISH;
              end
              default: state <= S_STOP;
            endcase
          end else if (timeout) begin
            // A stalled STOP cannot be retried, so finish the transaction directly.
            abort_flag <= 1'b1;
            if (ret_state == S_STOP) begin
              done  <= 1'b1;
              nack  <= nack_flag;
              abort <= 1'b1;
              state <= S_FINISH;
            end else begin
              state <= S_STOP;
            end
          end
        end
        S_FINISH: begin
          nack       <= 1'b0;
          abort      <= 1'b0;
          nack_flag  <= 1'b0;
          abort_flag <= 1'b0;
          req_ready  <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          wr_ready  <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: table of whole transactions applied against a small
// master responder, plus hand-written reset-mid-transaction and watchdog cases.
module tb_i2c_txn_sequencer;
  import i2c_txn_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [6:0] req_addr = '0;
  logic       req_rw = 1'b0;
  logic [3:0] req_len = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = '0;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       done, nack, abort;
  logic [2:0] cmd;
  logic [7:0] tx_byte;
  logic       write;
  logic       m_ready = 1'b1;
  logic       m_done = 1'b0;
  logic       m_ack = 1'b1;
  logic [7:0] m_rx_byte = '0;

  int checks = 0;
  int failures = 0;

  i2c_txn_sequencer #(.LEN_W(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rw(req_rw), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .nack(nack), .abort(abort),
    .cmd(cmd), .tx_byte(tx_byte), .write(write),
    .m_ready(m_ready), .m_done(m_done), .m_ack(m_ack), .m_rx_byte(m_rx_byte)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            rw;
    logic [6:0]      addr;
    logic [3:0]      len;
    logic [2:0][7:0] data;   // bytes to write, or bytes the master returns
    logic [7:0]      ackm;   // ack for the i-th WRITE command (bit 0 = address)
    int              hold;   // cycles m_ready is held low before START
    int              nwr;    // write bytes the sequencer should request
    int              nrd;    // rd_valid pulses expected
    logic            enack;
    int              ncmd;
    logic [5:0][2:0] ecmd;
    logic [5:0][7:0] ebyte;
  } vec_t;

  vec_t vt[6];

  function automatic vec_t mk(input logic rw, input logic [6:0] a, input logic [3:0] len,
                              input logic [7:0] d0, d1, d2, input logic [7:0] ackm,
                              input int hold, nwr, nrd, input logic enack, input int ncmd,
                              input logic [2:0] c0, c1, c2, c3, c4, c5,
                              input logic [7:0] b0, b1, b2, b3, b4, b5);
    vec_t v;
    v.rw = rw; v.addr = a; v.len = len;
    v.data[0] = d0; v.data[1] = d1; v.data[2] = d2;
    v.ackm = ackm; v.hold = hold; v.nwr = nwr; v.nrd = nrd; v.enack = enack; v.ncmd = ncmd;
    v.ecmd[0] = c0; v.ecmd[1] = c1; v.ecmd[2] = c2; v.ecmd[3] = c3; v.ecmd[4] = c4; v.ecmd[5] = c5;
    v.ebyte[0] = b0; v.ebyte[1] = b1; v.ebyte[2] = b2; v.ebyte[3] = b3; v.ebyte[4] = b4; v.ebyte[5] = b5;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk(nm, {6'd0, req_ready, wr_ready, rd_valid, rd_data, done, nack, abort, cmd, tx_byte, write},
            {6'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, k_IDLE_CMD, 8'h00, 1'b0});
  endtask

  // Run one table transaction; the bench acts as the master and the write-byte source.
  task automatic run_txn(input vec_t v, input string nm);
    int ci = 0, wi = 0, ri = 0, rdi = 0, wseen = 0, cyc = 0;
    int first_w = -1, stop_cyc = -1, done_cyc = -1, bad_i = -1;
    bit hold_ok = 1'b1, got_done = 1'b0, rd_ok = 1'b1;
    logic [10:0] bad_act = '0, bad_exp = '0;
    logic dn_nack = 1'b0, dn_abort = 1'b0;
    @(negedge clk);
    chk({nm, "_req_ready_idle"}, req_ready, 1);
    if (v.hold > 0) m_ready = 1'b0;
    req_valid = 1'b1; req_addr = v.addr; req_rw = v.rw; req_len = v.len;
    while (!got_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      m_done = 1'b0;
      if (cyc <= v.hold) begin
        if (write || req_ready) hold_ok = 1'b0;
        m_ready = 1'b0;
        req_valid = 1'b1; req_addr = 7'h0F; req_rw = ~v.rw; req_len = 4'hF;
      end else begin
        m_ready = 1'b1;
        req_valid = 1'b0;
      end
      if (done) begin
        got_done = 1'b1; done_cyc = cyc; dn_nack = nack; dn_abort = abort;
      end
      if (rd_valid) begin
        if (ri >= v.nrd || ri > 2) rd_ok = 1'b0;
        else if (rd_data !== v.data[ri]) rd_ok = 1'b0;
        ri++;
      end
      if (write) begin
        if (first_w < 0) first_w = cyc;
        if (bad_i < 0) begin
          if (ci >= v.ncmd) begin
            bad_i = ci; bad_act = {cmd, tx_byte}; bad_exp = 11'h7FF;
          end else if (cmd !== v.ecmd[ci] ||
                       (cmd == k_WRITE_CMD && tx_byte !== v.ebyte[ci])) begin
            bad_i = ci; bad_act = {cmd, tx_byte}; bad_exp = {v.ecmd[ci], v.ebyte[ci]};
          end
        end
        if (cmd == k_STOP_CMD) stop_cyc = cyc;
        m_done = 1'b1;
        m_ack = 1'b1;
        if (cmd == k_WRITE_CMD) begin
          if (wseen < 8) m_ack = v.ackm[wseen];
          wseen++;
        end
        if (cmd == k_READ_ACK_CMD || cmd == k_READ_NACK_CMD) begin
          m_rx_byte = (rdi < 3) ? v.data[rdi] : 8'h00;
          rdi++;
        end
        ci++;
      end
      if (wr_ready) begin
        wr_valid = 1'b1;
        wr_data = (wi < 3) ? v.data[wi] : 8'h00;
      end else begin
        if (wr_valid) wi++;
        wr_valid = 1'b0;
      end
    end
    chk({nm, "_done_seen"}, got_done, 1);
    chk({nm, "_cmd_seq_first_bad_index"}, bad_i, -1);
    if (bad_i >= 0) chk({nm, "_cmd_seq_bad_cmd_byte"}, bad_act, bad_exp);
    chk({nm, "_cmd_count"}, ci, v.ncmd);
    chk({nm, "_rd_bytes_ok"}, rd_ok, 1);
    chk({nm, "_rd_count"}, ri, v.nrd);
    chk({nm, "_wr_fetch_count"}, wi, v.nwr);
    chk({nm, "_nack"}, dn_nack, v.enack);
    chk({nm, "_abort"}, dn_abort, 0);
    chk({nm, "_start_latency"}, first_w, v.hold + 2);
    chk({nm, "_done_after_stop"}, done_cyc, stop_cyc + 1);
    if (v.hold > 0) chk({nm, "_hold_no_write_no_ready"}, hold_ok, 1);
    @(negedge clk);
    m_done = 1'b0;
    chk({nm, "_idle_after_done"}, {done, req_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1);
  end

  initial begin
    // Fields: rw addr len d0 d1 d2 ackm hold nwr nrd enack ncmd cmds[6] bytes[6]
    vt[0] = mk(1'b0, 7'h50, 4'd2, 8'hA5, 8'h3C, 8'h00, 8'hFF, 0, 2, 0, 1'b0, 5,
               k_START_CMD, k_WRITE_CMD, k_WRITE_CMD, k_WRITE_CMD, k_STOP_CMD, k_IDLE_CMD,
               8'h00, 8'hA0, 8'hA5, 8'h3C, 8'h00, 8'h00);
    vt[1] = mk(1'b1, 7'h48, 4'd3, 8'h11, 8'h22, 8'h33, 8'hFF, 0, 0, 3, 1'b0, 6,
               k_START_CMD, k_WRITE_CMD, k_READ_ACK_CMD, k_READ_ACK_CMD, k_READ_NACK_CMD, k_STOP_CMD,
               8'h00, 8'h91, 8'h00, 8'h00, 8'h00, 8'h00);
    vt[2] = mk(1'b0, 7'h20, 4'd0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1'b1, 3,
               k_START_CMD, k_WRITE_CMD, k_STOP_CMD, k_IDLE_CMD, k_IDLE_CMD, k_IDLE_CMD,
               8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00);
    vt[3] = mk(1'b0, 7'h3A, 4'd3, 8'h01, 8'h02, 8'h03, 8'b0000_0011, 0, 2, 0, 1'b1, 5,
               k_START_CMD, k_WRITE_CMD, k_WRITE_CMD, k_WRITE_CMD, k_STOP_CMD, k_IDLE_CMD,
               8'h00, 8'h74, 8'h01, 8'h02, 8'h00, 8'h00);
    vt[4] = mk(1'b1, 7'h7F, 4'd1, 8'hC3, 8'h00, 8'h00, 8'hFF, 20, 0, 1, 1'b0, 4,
               k_START_CMD, k_WRITE_CMD, k_READ_NACK_CMD, k_STOP_CMD, k_IDLE_CMD, k_IDLE_CMD,
               8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
    vt[5] = mk(1'b1, 7'h10, 4'd2, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1'b1, 3,
               k_START_CMD, k_WRITE_CMD, k_STOP_CMD, k_IDLE_CMD, k_IDLE_CMD, k_IDLE_CMD,
               8'h00, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00);

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset_during");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset_released");

    for (int i = 0; i < 6; i++) begin
      run_txn(vt[i], $sformatf("vec%0d", i));
    end

    // Reset while the first data byte's WRITE is outstanding.
    begin
      int nw = 0, cyc = 0;
      bit reached = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_addr = 7'h33; req_rw = 1'b0; req_len = 4'd2;
      while (!reached && cyc < 60) begin
        @(negedge clk);
        cyc++;
        req_valid = 1'b0;
        m_done = 1'b0;
        if (write) begin
          if (cmd == k_WRITE_CMD) nw++;
          if (nw == 2) reached = 1'b1;
          else begin m_done = 1'b1; m_ack = 1'b1; end
        end
        if (wr_ready) begin wr_valid = 1'b1; wr_data = 8'h5E; end
        else wr_valid = 1'b0;
      end
      chk("rst_mid_wdata_reached", reached, 1);
      chk("rst_mid_wdata_tx_byte_before", tx_byte, 8'h5E);
      reset = 1'b1;
      #1;
      chk_reset_outputs("rst_mid_wdata_outputs");
      @(negedge clk);
      chk_reset_outputs("rst_mid_wdata_next_cycle");
      reset = 1'b0;
      wr_valid = 1'b0;
      m_done = 1'b0;
      @(negedge clk);
      chk_reset_outputs("rst_mid_wdata_released");
    end
    run_txn(vt[0], "after_reset_vec0");

`ifdef I2C_SEQ_TIMEOUT_EN
    // Address WRITE is never completed: the watchdog forces STOP and flags abort.
    begin
      int cyc = 0, addr_cyc = -1, stop_cyc = -1, wreq = 0;
      bit got_done = 1'b0;
      logic dn_nack = 1'b0, dn_abort = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_addr = 7'h50; req_rw = 1'b0; req_len = 4'd1;
      while (!got_done && cyc < 200) begin
        @(negedge clk);
        cyc++;
        req_valid = 1'b0;
        m_done = 1'b0;
        if (done) begin got_done = 1'b1; dn_nack = nack; dn_abort = abort; end
        if (wr_ready) wreq++;
        if (write) begin
          if (cmd == k_START_CMD) begin m_done = 1'b1; m_ack = 1'b1; end
          else if (cmd == k_WRITE_CMD) addr_cyc = cyc;
          else if (cmd == k_STOP_CMD) begin stop_cyc = cyc; m_done = 1'b1; end
        end
      end
      chk("timeout_done_seen", got_done, 1);
      chk("timeout_abort", dn_abort, 1);
      chk("timeout_nack", dn_nack, 0);
      chk("timeout_no_wr_request", wreq, 0);
      chk("timeout_stop_gap_in_range",
          (addr_cyc > 0 && stop_cyc - addr_cyc >= 16 && stop_cyc - addr_cyc <= 18), 1);
      @(negedge clk);
      m_done = 1'b0;
      chk("timeout_idle_after", {abort, req_ready}, 2'b01);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
